// File: rtl/cpld_pkg.sv
// cpld_pkg: shared encodings for the CPLD blocks.
// Contents: arb_state_t (flash arbiter FSM state) and owner encodings
// OWNER_DSP / OWNER_CPU used for round-robin tie breaking.
package cpld_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DSP_OWN = 2'd1,
        CPU_OWN = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam logic OWNER_DSP = 1'b0;
    localparam logic OWNER_CPU = 1'b1;
endpackage

// File: rtl/spi_flash_arbiter_if.sv
// spi_flash_arbiter_if: SPI signals between the two masters, the shared flash and the arbiter.
// master modport: board side (drives master SPI inputs, cpu_enable, flash_miso).
// slave modport:  arbiter side (drives flash pins, master MISO lines, grants, contention count).
interface spi_flash_arbiter_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 cpu_enable;
    logic                 dsp_spi_clk;
    logic                 dsp_spi_mosi;
    logic                 dsp_spi_cs_INV;
    logic                 dsp_spi_miso;
    logic                 cpu_spi_clk;
    logic                 cpu_spi_mosi;
    logic                 cpu_spi_cs_INV;
    logic                 cpu_spi_miso;
    logic                 flash_clk;
    logic                 flash_mosi;
    logic                 flash_cs_INV;
    logic                 flash_miso;
    logic                 dsp_grant;
    logic                 cpu_grant;
    logic [CNT_WIDTH-1:0] contention_count;

    modport master (
        output cpu_enable, dsp_spi_clk, dsp_spi_mosi, dsp_spi_cs_INV,
               cpu_spi_clk, cpu_spi_mosi, cpu_spi_cs_INV, flash_miso,
        input  dsp_spi_miso, cpu_spi_miso, flash_clk, flash_mosi, flash_cs_INV,
               dsp_grant, cpu_grant, contention_count
    );

    modport slave (
        input  cpu_enable, dsp_spi_clk, dsp_spi_mosi, dsp_spi_cs_INV,
               cpu_spi_clk, cpu_spi_mosi, cpu_spi_cs_INV, flash_miso,
        output dsp_spi_miso, cpu_spi_miso, flash_clk, flash_mosi, flash_cs_INV,
               dsp_grant, cpu_grant, contention_count
    );
endinterface

// File: rtl/cs_sync.sv
// cs_sync: SYNC_STAGES flip-flop synchroniser for an active-low chip select.
// Ports: clk_i, rst_i (sync, active-high), d_i (async CS), q_o (synchronised CS).
// Resets to 1 so a held-off master reads as "not selected".
module cs_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: shares one SPI flash between the DSP and CPU masters.
// Ports: sysclk (UFM oscillator), reset (sync, active-high), bus (slave modport):
//   master SPI inputs + cpu_enable in, master MISO out, flash pins out/in,
//   registered dsp_grant/cpu_grant and saturating contention_count out.
// Round-robin on ties, turnaround gap between owners, grant-gated steering.
module spi_flash_arbiter
    import cpld_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int TURNAROUND_CYCLES = 4,
    parameter int CNT_WIDTH         = 8
) (
    input  logic                 sysclk,
    input  logic                 reset,
    spi_flash_arbiter_if.slave   bus
);
    localparam int TW = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;

    logic                 dsp_cs_sync, cpu_cs_sync;
    logic                 dsp_req, cpu_req;
    logic                 dsp_req_q, cpu_req_q;
    logic                 contend;
    arb_state_t           state_q, state_d;
    logic                 last_owner_q, last_owner_d;
    logic [TW-1:0]        turn_q, turn_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    cs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dsp_sync (
        .clk_i (sysclk),
        .rst_i (reset),
        .d_i   (bus.dsp_spi_cs_INV),
        .q_o   (dsp_cs_sync)
    );

    cs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cpu_sync (
        .clk_i (sysclk),
        .rst_i (reset),
        .d_i   (bus.cpu_spi_cs_INV),
        .q_o   (cpu_cs_sync)
    );

    assign dsp_req = ~dsp_cs_sync;
    assign cpu_req = ~cpu_cs_sync & bus.cpu_enable;

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        turn_d       = turn_q;
        case (state_q)
            IDLE: begin
                if (dsp_req && (!cpu_req || last_owner_q == OWNER_CPU)) state_d = DSP_OWN;
                else if (cpu_req)                                      state_d = CPU_OWN;
            end
            DSP_OWN: begin
                if (!dsp_req) begin
                    state_d      = RELEASE;
                    turn_d       = TW'(TURNAROUND_CYCLES - 1);
                    last_owner_d = OWNER_DSP;
                end
            end
            CPU_OWN: begin
                if (!cpu_req) begin
                    state_d      = RELEASE;
                    turn_d       = TW'(TURNAROUND_CYCLES - 1);
                    last_owner_d = OWNER_CPU;
                end
            end
            RELEASE: begin
                if (turn_q == '0) state_d = IDLE;
                else              turn_d  = turn_q - 1'b1;
            end
        endcase
    end

    // A denied request is a fresh request that finds the flash busy, or the
    // losing side of a same-cycle tie in IDLE.
    assign contend = (dsp_req && !dsp_req_q && (state_q == CPU_OWN || state_q == RELEASE))
                  || (cpu_req && !cpu_req_q && (state_q == DSP_OWN || state_q == RELEASE))
                  || (state_q == IDLE && dsp_req && cpu_req);
    assign cnt_d   = (contend && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_CPU;
            turn_q       <= '0;
            cnt_q        <= '0;
            dsp_req_q    <= 1'b0;
            cpu_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            turn_q       <= turn_d;
            cnt_q        <= cnt_d;
            dsp_req_q    <= dsp_req;
            cpu_req_q    <= cpu_req;
        end
    end

    assign bus.dsp_grant        = (state_q == DSP_OWN);
    assign bus.cpu_grant        = (state_q == CPU_OWN);
    assign bus.contention_count = cnt_q;

    // Raw master signals pass only through the registered grant, so a
    // non-owner's CS or SCLK activity can never reach the flash.
    always @(*) begin
        bus.flash_clk    = bus.dsp_grant ? bus.dsp_spi_clk    : bus.cpu_grant ? bus.cpu_spi_clk    : 1'b0;
        bus.flash_mosi   = bus.dsp_grant ? bus.dsp_spi_mosi   : bus.cpu_grant ? bus.cpu_spi_mosi   : 1'b0;
        bus.flash_cs_INV = bus.dsp_grant ? bus.dsp_spi_cs_INV : bus.cpu_grant ? bus.cpu_spi_cs_INV : 1'b1;
        bus.dsp_spi_miso = bus.dsp_grant ? bus.flash_miso : 1'b1;
        bus.cpu_spi_miso = bus.cpu_grant ? bus.flash_miso : 1'b1;
    end
endmodule
